aes_sec_wipe_ctrl: RTL and testbench
====================================

AES_SEC_WIPE_CTRL -- requirements
Module: aes_sec_wipe_ctrl

Interface
REQ-001 Parameter Width, default 64: bit width of each PRNG share and each written word.
REQ-002 Parameter NumShares, default 2: number of data shares written per slot.
REQ-003 Parameter NumSlots, default 8 (legal range 2..16): number of register slots wiped per operation.
REQ-004 Port clk_i, input, 1: sole clock.
REQ-005 Port rst_i, input, 1: reset; synchronous, active-high.
REQ-006 Port wipe_req_i, input, 1: wipe request; held high until wipe_ack_o.
REQ-007 Port wipe_reseed_i, input, 1: sampled with the accepted wipe_req_i; when set, a PRNG reseed precedes the wipe.
REQ-008 Port wipe_ack_o, output, 1: one-cycle completion pulse.
REQ-009 Port abort_i, input, 1: abandons the current operation.
REQ-010 Port busy_o, output, 1: high whenever the FSM is not IDLE.
REQ-011 Port prng_data_req_o, output, 1: data request to the clearing PRNG.
REQ-012 Port prng_data_ack_i, input, 1: data accepted and valid in the same cycle.
REQ-013 Port prng_data_i, input, NumShares x Width: PRNG output shares.
REQ-014 Port prng_reseed_req_o, output, 1: reseed request to the clearing PRNG.
REQ-015 Port prng_reseed_ack_i, input, 1: reseed complete.
REQ-016 Port wr_en_o, output, NumSlots: one-hot slot write strobe.
REQ-017 Port wr_data_o, output, NumShares x Width: data written to the strobed slot.

Function
REQ-018 The FSM SHALL have the states IDLE, RESEED, WIPE and DONE.
REQ-019 IDLE SHALL leave on wipe_req_i=1 with abort_i=0: to RESEED if wipe_reseed_i=1, else to WIPE; the slot counter SHALL be cleared to 0 on this transition.
REQ-020 RESEED SHALL drive prng_reseed_req_o=1 and prng_data_req_o=0, and SHALL move to WIPE in the cycle after prng_reseed_ack_i=1.
REQ-021 WIPE SHALL drive prng_data_req_o=1; each cycle with prng_data_ack_i=1 SHALL register wr_en_o=onehot(slot counter) and wr_data_o=prng_data_i, then increment the counter.
REQ-022 The write SHALL appear exactly 1 cycle after the ack; wr_en_o SHALL be all-zero in every other cycle.
REQ-023 Cycles in WIPE with prng_data_ack_i=0 SHALL hold the counter and produce no write; the request SHALL stay asserted.
REQ-024 The ack for slot NumSlots-1 SHALL move the FSM to DONE; the counter SHALL NOT wrap, and prng_data_req_o SHALL drop in DONE.
REQ-025 DONE SHALL assert wipe_ack_o for exactly one cycle (this cycle coincides with the last slot's wr_en_o) and return to IDLE.
REQ-026 A new wipe_req_i in the cycle after DONE SHALL be accepted as a fresh operation.
REQ-027 abort_i=1 in any state SHALL return to IDLE next cycle with no wipe_ack_o; an ack arriving in the same cycle SHALL still produce its registered write.
REQ-028 prng_reseed_req_o and prng_data_req_o SHALL never be high in the same cycle.
REQ-029 Once raised, a PRNG request SHALL stay high until its ack or abort.
REQ-030 The counter width SHALL be $clog2(NumSlots).

Reset
REQ-031 rst_i=1 SHALL force the following on the next clock edge, overriding all other inputs: state IDLE, counter 0, wr_en_o=0, wr_data_o=0, wipe_ack_o=0, busy_o=0, both PRNG requests 0.
REQ-032 Reset asserted mid-WIPE SHALL discard the pending write and produce no wipe_ack_o.

Structure
REQ-033 The state enum (aes_wipe_state_e) and the default slot count constant (NumWipeSlotsDefault) SHALL reside in aes_pkg.
REQ-034 The FSM SHALL use sparse, Hamming-distance-3 encoding; an illegal state SHALL go to IDLE and assert no request or strobe.
REQ-035 The block SHALL be a single module with no sub-module instances; the counter is inline.

Verification
REQ-036 Basic wipe: wipe_req=1, wipe_reseed=0, data_ack tied 1 -> wr_en_o = 0x01, 0x02 ... 0x80 on 8 consecutive cycles, wipe_ack pulses with 0x80, total 10 cycles from request.
REQ-037 Reseed first: wipe_reseed=1, reseed_ack after 5 cycles -> no data_req during RESEED, then 8 writes, exactly one wipe_ack.
REQ-038 Stalled ack: data_ack toggles 1,0,1,0 -> writes only after ack cycles, wr_data equals prng_data sampled at each ack, 8 writes total.
REQ-039 Abort at slot 3 -> writes for slots 0..3 only, busy_o=0 next cycle, no wipe_ack.
REQ-040 Reset during WIPE -> all outputs 0 next cycle; a subsequent request starts again at slot 0.
REQ-041 Back-to-back requests -> the second operation starts the cycle after wipe_ack and produces 8 fresh writes.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: wipe-controller state encoding and default slot count.
package aes_pkg;

  // Number of register slots cleared by one wipe operation unless overridden.
  localparam int unsigned NumWipeSlotsDefault = 8;

  // Sparse encoding: every pair of legal states differs in at least 3 bits,
  // so a single upset cannot turn one legal state into another.
  typedef enum logic [4:0] {
    AES_WIPE_IDLE   = 5'b00000,
    AES_WIPE_RESEED = 5'b00111,
    AES_WIPE_WIPE   = 5'b11001,
    AES_WIPE_DONE   = 5'b11110
  } aes_wipe_state_e;

endpackage

// File: rtl/aes_sec_wipe_ctrl.sv
// Secure wipe controller: optionally reseeds the clearing PRNG, then overwrites
// NumSlots register slots with fresh PRNG shares, one slot per PRNG ack.
module aes_sec_wipe_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned Width     = 64,
  parameter int unsigned NumShares = 2,
  parameter int unsigned NumSlots  = NumWipeSlotsDefault
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 wipe_req_i,
  input  logic                                 wipe_reseed_i,
  output logic                                 wipe_ack_o,
  input  logic                                 abort_i,
  output logic                                 busy_o,
  output logic                                 prng_data_req_o,
  input  logic                                 prng_data_ack_i,
  input  logic [NumShares-1:0][Width-1:0]      prng_data_i,
  output logic                                 prng_reseed_req_o,
  input  logic                                 prng_reseed_ack_i,
  output logic [NumSlots-1:0]                  wr_en_o,
  output logic [NumShares-1:0][Width-1:0]      wr_data_o
);

  localparam int unsigned CntW = $clog2(NumSlots);
  localparam logic [CntW-1:0] LastSlot = CntW'(NumSlots - 1);

  aes_wipe_state_e                 r_state;
  aes_wipe_state_e                 w_state_nxt;
  logic [CntW-1:0]                 r_cnt;
  logic [CntW-1:0]                 w_cnt_nxt;
  logic [NumSlots-1:0]             r_wr_en;
  logic [NumSlots-1:0]             w_wr_en_nxt;
  logic [NumShares-1:0][Width-1:0] r_wr_data;
  logic [NumShares-1:0][Width-1:0] w_wr_data_nxt;
  logic                            r_wipe_ack;
  logic                            w_wipe_ack_nxt;
  logic [NumSlots-1:0]             w_onehot;

  assign w_onehot = {{(NumSlots-1){1'b0}}, 1'b1} << r_cnt;

  // Next-state, counter and write-strobe logic; an undefined state falls back to IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_wr_en_nxt    = {NumSlots{1'b0}};
    w_wr_data_nxt  = r_wr_data;
    w_wipe_ack_nxt = 1'b0;
    case (r_state)
      AES_WIPE_IDLE: begin
        if (wipe_req_i && !abort_i) begin
          w_cnt_nxt   = {CntW{1'b0}};
          w_state_nxt = wipe_reseed_i ? AES_WIPE_RESEED : AES_WIPE_WIPE;
        end else begin
          w_state_nxt = AES_WIPE_IDLE;
        end
      end
      AES_WIPE_RESEED: begin
        if (abort_i) begin
          w_state_nxt = AES_WIPE_IDLE;
        end else if (prng_reseed_ack_i) begin
          w_state_nxt = AES_WIPE_WIPE;
        end else begin
          w_state_nxt = AES_WIPE_RESEED;
        end
      end
      AES_WIPE_WIPE: begin
        if (prng_data_ack_i) begin
          // An accepted PRNG word is always written, even when aborting.
          w_wr_en_nxt   = w_onehot;
          w_wr_data_nxt = prng_data_i;
          if (r_cnt == LastSlot) begin
            // Counter is left at the last slot rather than wrapping.
            if (abort_i) begin
              w_state_nxt = AES_WIPE_IDLE;
            end else begin
              w_state_nxt    = AES_WIPE_DONE;
              w_wipe_ack_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt   = r_cnt + CntW'(1);
            w_state_nxt = abort_i ? AES_WIPE_IDLE : AES_WIPE_WIPE;
          end
        end else if (abort_i) begin
          w_state_nxt = AES_WIPE_IDLE;
        end else begin
          w_state_nxt = AES_WIPE_WIPE;
        end
      end
      AES_WIPE_DONE: begin
        w_state_nxt = AES_WIPE_IDLE;
      end
      default: begin
        w_state_nxt = AES_WIPE_IDLE;
        w_cnt_nxt   = {CntW{1'b0}};
      end
    endcase
  end

  // State, counter and registered write/ack outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= AES_WIPE_IDLE;
      r_cnt      <= {CntW{1'b0}};
      r_wr_en    <= {NumSlots{1'b0}};
      r_wr_data  <= '0;
      r_wipe_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_wipe_ack <= w_wipe_ack_nxt;
    end
  end

  // Requests decode only from exact legal state codes, so an illegal state
  // raises neither request and the two can never be high together.
  assign prng_reseed_req_o = (r_state == AES_WIPE_RESEED);
  assign prng_data_req_o   = (r_state == AES_WIPE_WIPE);
  assign busy_o            = (r_state != AES_WIPE_IDLE);
  assign wipe_ack_o        = r_wipe_ack;
  assign wr_en_o           = r_wr_en;
  assign wr_data_o         = r_wr_data;

endmodule

// File: tb/tb_aes_sec_wipe_ctrl.sv
// Directed self-checking bench for aes_sec_wipe_ctrl (default parameters).
module tb_aes_sec_wipe_ctrl;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             wipe_req_i;
  logic             wipe_reseed_i;
  logic             wipe_ack_o;
  logic             abort_i;
  logic             busy_o;
  logic             prng_data_req_o;
  logic             prng_data_ack_i;
  logic [1:0][63:0] prng_data_i;
  logic             prng_reseed_req_o;
  logic             prng_reseed_ack_i;
  logic [7:0]       wr_en_o;
  logic [1:0][63:0] wr_data_o;

  int n_vec = 0;
  int n_err = 0;

  aes_sec_wipe_ctrl #(
    .Width     (64),
    .NumShares (2),
    .NumSlots  (8)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .wipe_req_i        (wipe_req_i),
    .wipe_reseed_i     (wipe_reseed_i),
    .wipe_ack_o        (wipe_ack_o),
    .abort_i           (abort_i),
    .busy_o            (busy_o),
    .prng_data_req_o   (prng_data_req_o),
    .prng_data_ack_i   (prng_data_ack_i),
    .prng_data_i       (prng_data_i),
    .prng_reseed_req_o (prng_reseed_req_o),
    .prng_reseed_ack_i (prng_reseed_ack_i),
    .wr_en_o           (wr_en_o),
    .wr_data_o         (wr_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit later, check request exclusivity.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("req_exclusive", {127'd0, prng_data_req_o & prng_reseed_req_o}, 128'd0);
  endtask

  // Idle-state output check.
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {127'd0, busy_o}, 128'd0);
    chk({tag, "_wr_en"}, {120'd0, wr_en_o}, 128'd0);
    chk({tag, "_ack"}, {127'd0, wipe_ack_o}, 128'd0);
    chk({tag, "_dreq"}, {127'd0, prng_data_req_o}, 128'd0);
    chk({tag, "_rreq"}, {127'd0, prng_reseed_req_o}, 128'd0);
  endtask

  // From WIPE at slot 0, feed PRNG words until n slots are written.
  // With stall set, the ack alternates 1,0,1,0.
  task automatic run_wipe(input bit stall, input int n);
    int slot;
    logic [127:0] d;
    logic [7:0] exp_en;
    bit a;
    slot = 0;
    for (int j = 0; j < 16 && slot < n; j++) begin
      a = stall ? (j % 2 == 0) : 1'b1;
      d = {$urandom, $urandom, $urandom, $urandom};
      prng_data_ack_i = a;
      prng_data_i = d;
      tick();
      if (a) begin
        exp_en = 8'd1 << slot;
        chk("wr_en", {120'd0, wr_en_o}, {120'd0, exp_en});
        chk("wr_data", wr_data_o, d);
        chk("wipe_ack", {127'd0, wipe_ack_o}, {127'd0, (slot == 7)});
        chk("dreq_after_write", {127'd0, prng_data_req_o}, {127'd0, (slot != 7)});
        slot++;
      end else begin
        chk("stall_wr_en", {120'd0, wr_en_o}, 128'd0);
        chk("stall_dreq", {127'd0, prng_data_req_o}, 128'd1);
        chk("stall_ack", {127'd0, wipe_ack_o}, 128'd0);
      end
    end
    prng_data_ack_i = 1'b0;
  endtask

  // Accept a plain wipe request and confirm entry into WIPE.
  task automatic start_wipe(input string tag);
    wipe_req_i = 1'b1;
    wipe_reseed_i = 1'b0;
    prng_data_ack_i = 1'b0;
    tick();
    chk({tag, "_busy"}, {127'd0, busy_o}, 128'd1);
    chk({tag, "_dreq"}, {127'd0, prng_data_req_o}, 128'd1);
    chk({tag, "_wr_en"}, {120'd0, wr_en_o}, 128'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    wipe_req_i = 1'b0;
    wipe_reseed_i = 1'b0;
    abort_i = 1'b0;
    prng_data_ack_i = 1'b0;
    prng_data_i = '0;
    prng_reseed_ack_i = 1'b0;

    // Reset state.
    tick();
    tick();
    chk_idle("reset");
    chk("reset_wr_data", wr_data_o, 128'd0);
    rst_i = 1'b0;
    tick();
    chk_idle("post_reset");

    // Basic wipe, ack tied high: 0x01..0x80, ack with 0x80, idle on cycle 10.
    start_wipe("basic");
    run_wipe(1'b0, 8);
    wipe_req_i = 1'b0;
    tick();
    chk_idle("basic_end");

    // Reseed first: reseed ack after 5 cycles, no data request meanwhile.
    wipe_req_i = 1'b1;
    wipe_reseed_i = 1'b1;
    prng_data_ack_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rs_rreq", {127'd0, prng_reseed_req_o}, 128'd1);
      chk("rs_dreq", {127'd0, prng_data_req_o}, 128'd0);
      chk("rs_wr_en", {120'd0, wr_en_o}, 128'd0);
      wipe_reseed_i = 1'b0;
    end
    prng_reseed_ack_i = 1'b1;
    prng_data_ack_i = 1'b0;
    tick();
    prng_reseed_ack_i = 1'b0;
    chk("rs_to_wipe_rreq", {127'd0, prng_reseed_req_o}, 128'd0);
    chk("rs_to_wipe_dreq", {127'd0, prng_data_req_o}, 128'd1);
    run_wipe(1'b0, 8);
    wipe_req_i = 1'b0;
    tick();
    chk_idle("rs_end");

    // Stalled ack: writes only after ack cycles.
    start_wipe("stall");
    run_wipe(1'b1, 8);
    wipe_req_i = 1'b0;
    tick();
    chk_idle("stall_end");

    // Abort together with the ack for slot 3: that write still lands.
    start_wipe("abort");
    run_wipe(1'b0, 3);
    prng_data_ack_i = 1'b1;
    prng_data_i = {64'hDEAD_BEEF_0000_0003, 64'h0123_4567_89AB_CDEF};
    abort_i = 1'b1;
    tick();
    chk("abort_wr_en", {120'd0, wr_en_o}, 128'h08);
    chk("abort_wr_data", wr_data_o, {64'hDEAD_BEEF_0000_0003, 64'h0123_4567_89AB_CDEF});
    chk("abort_busy", {127'd0, busy_o}, 128'd0);
    chk("abort_ack", {127'd0, wipe_ack_o}, 128'd0);
    abort_i = 1'b0;
    wipe_req_i = 1'b0;
    prng_data_ack_i = 1'b0;
    tick();
    chk_idle("abort_after");

    // Reset mid-wipe discards the pending write; restart begins at slot 0.
    start_wipe("rst");
    run_wipe(1'b0, 2);
    prng_data_ack_i = 1'b1;
    prng_data_i = {$urandom, $urandom, $urandom, $urandom};
    rst_i = 1'b1;
    tick();
    chk_idle("rst_mid");
    chk("rst_mid_wr_data", wr_data_o, 128'd0);
    rst_i = 1'b0;
    prng_data_ack_i = 1'b0;
    tick();
    chk("rst_restart_busy", {127'd0, busy_o}, 128'd1);
    run_wipe(1'b0, 8);
    wipe_req_i = 1'b0;
    tick();
    chk_idle("rst_end");

    // Back-to-back: request held through the ack is taken in the following IDLE cycle.
    start_wipe("b2b");
    run_wipe(1'b0, 8);
    tick();
    chk_idle("b2b_gap");
    tick();
    chk("b2b_busy", {127'd0, busy_o}, 128'd1);
    chk("b2b_dreq", {127'd0, prng_data_req_o}, 128'd1);
    run_wipe(1'b1, 8);
    wipe_req_i = 1'b0;
    tick();
    chk_idle("b2b_end");

    // Abort while in RESEED returns to IDLE with no ack.
    wipe_req_i = 1'b1;
    wipe_reseed_i = 1'b1;
    tick();
    chk("rsab_rreq", {127'd0, prng_reseed_req_o}, 128'd1);
    abort_i = 1'b1;
    wipe_req_i = 1'b0;
    wipe_reseed_i = 1'b0;
    tick();
    chk_idle("rsab_end");
    abort_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
